// File: rtl/trace_pkg.sv
// Shared types and widths for the commit trace packer.
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN (adds a cycle timestamp to every record).
package trace_pkg;

  localparam int unsigned SeqWDefault = 16;
  localparam int unsigned DropCntW    = 16;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  localparam int unsigned TsW         = 32;
`endif

  typedef struct packed {
    logic [SeqWDefault-1:0] seq;
    logic [63:0]            pc;
    logic [31:0]            instr;
    logic [4:0]             rd;
    logic                   we;
    logic [63:0]            wdata;
    logic                   ex_valid;
    logic [63:0]            ex_cause;
    logic [1:0]             priv;
    logic                   dbg;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [TsW-1:0]         timestamp;
`endif
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Two-write / one-read record FIFO. Writes are compacted: wr_num_i records are taken from
// wr_data0_i then wr_data1_i. Reports occupancy and free space including this cycle's pop.
module trace_fifo_2w1r
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic [1:0]    wr_num_i,
  input  trace_rec_t    wr_data0_i,
  input  trace_rec_t    wr_data1_i,
  input  logic          rd_ready_i,
  output trace_rec_t    rd_data_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] free_o
);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          not_empty;
  logic          pop;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty & rd_ready_i;
  assign count_o   = count_q;
  assign free_o    = CW'(DEPTH) - count_q + CW'(pop);
  // Head is gated so stale storage never shows when empty (storage itself has no reset).
  assign rd_data_o = not_empty ? mem_q[rptr_q] : '0;

  // Next-state pointers and occupancy; flush wins over everything.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + AW'(wr_num_i);
      rptr_d  = rptr_q + AW'(pop);
      count_d = count_q + CW'(wr_num_i) - CW'(pop);
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Record storage writes.
  always_ff @(posedge clk_i) begin
    if (!flush_i && (wr_num_i != 2'd0)) mem_q[wptr_q] <= wr_data0_i;
    if (!flush_i && (wr_num_i == 2'd2)) mem_q[wptr_q + AW'(1)] <= wr_data1_i;
  end

endmodule

// File: rtl/commit_trace_packer.sv
// Commit-side trace producer: tags up to two retiring instructions per cycle with a sequence
// number and context, buffers them and streams one record per cycle. Records that do not fit
// are dropped and counted. Optional macro COMMIT_TRACE_TIMESTAMP_EN adds a cycle timestamp.
module commit_trace_packer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = SeqWDefault
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [1:0]          commit_ack_i,
  input  logic [1:0][63:0]    commit_pc_i,
  input  logic [1:0][31:0]    commit_instr_i,
  input  logic [1:0][4:0]     commit_rd_i,
  input  logic [1:0]          commit_we_i,
  input  logic [1:0][63:0]    commit_wdata_i,
  input  logic [1:0]          commit_ex_valid_i,
  input  logic [1:0][63:0]    commit_ex_cause_i,
  input  logic [1:0]          priv_lvl_i,
  input  logic                debug_mode_i,
  output logic                trace_valid_o,
  input  logic                trace_ready_i,
  output trace_rec_t          trace_data_o,
  output logic [DropCntW-1:0] drop_cnt_o,
  output logic                overflow_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       fifo_free, fifo_count;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [SEQ_W-1:0]    port_seq [2];
  logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [DropCntW:0]   drop_sum;
  logic                overflow_q, overflow_d;
  logic [1:0]          n_ack, n_push, n_drop;
  trace_rec_t          rec [2];
  trace_rec_t          slot0;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TsW-1:0] ts_q;

  // Free-running cycle counter sampled into every record pushed this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + TsW'(1);
  end
`endif

  assign n_ack       = {1'b0, commit_ack_i[0]} + {1'b0, commit_ack_i[1]};
  assign port_seq[0] = seq_q;
  assign port_seq[1] = seq_q + SEQ_W'(commit_ack_i[0]);

  // Build one record per port; port 1 takes the next seq only if port 0 also retired.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rec[p]          = '0;
      rec[p].seq      = SeqWDefault'(port_seq[p]);
      rec[p].pc       = commit_pc_i[p];
      rec[p].instr    = commit_instr_i[p];
      rec[p].rd       = commit_rd_i[p];
      rec[p].we       = commit_we_i[p];
      rec[p].wdata    = commit_wdata_i[p];
      rec[p].ex_valid = commit_ex_valid_i[p];
      rec[p].ex_cause = commit_ex_cause_i[p];
      rec[p].priv     = priv_lvl_i;
      rec[p].dbg      = debug_mode_i;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      rec[p].timestamp = ts_q;
`endif
    end
  end

  // A lone port-1 ack goes into the first write slot.
  assign slot0 = commit_ack_i[0] ? rec[0] : rec[1];

  // Admission: oldest records win the available space; flushed pushes are not drops.
  always_comb begin
    n_push = '0;
    n_drop = '0;
    if (!flush_i) begin
      if (fifo_free >= CW'(n_ack)) n_push = n_ack;
      else                         n_push = fifo_free[1:0];
      n_drop = n_ack - n_push;
    end
    seq_d      = seq_q + SEQ_W'(n_ack);
    drop_sum   = {1'b0, drop_cnt_q} + (DropCntW + 1)'(n_drop);
    drop_cnt_d = drop_sum[DropCntW] ? '1 : drop_sum[DropCntW-1:0];
    overflow_d = overflow_q | (n_drop != 2'd0);
  end

  // Sequence, drop counter and sticky overflow; flush leaves them running.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seq_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .wr_num_i   (n_push),
    .wr_data0_i (slot0),
    .wr_data1_i (rec[1]),
    .rd_ready_i (trace_ready_i),
    .rd_data_o  (trace_data_o),
    .count_o    (fifo_count),
    .free_o     (fifo_free)
  );

  assign trace_valid_o = (fifo_count != '0);
  assign drop_cnt_o    = drop_cnt_q;
  assign overflow_o    = overflow_q;

endmodule
